// File: rtl/sio_8251_pkg.sv
// -----------------------------------------------------------------------------
// sio_8251_pkg
// Shared definitions for the 8251-compatible serial I/O blocks (TX, RX and the
// control-register block): FSM state encoding, character-length codes, mode /
// command bit positions, the per-frame context struct and a parity helper.
// -----------------------------------------------------------------------------
package sio_8251_pkg;

    // Transmit FSM state encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Character length codes (mode bits 3:2)
    localparam logic [1:0] CHLEN_5 = 2'd0;
    localparam logic [1:0] CHLEN_6 = 2'd1;
    localparam logic [1:0] CHLEN_7 = 2'd2;
    localparam logic [1:0] CHLEN_8 = 2'd3;

    // Mode register bit positions
    localparam int MODE_CHLEN_LSB = 2;
    localparam int MODE_PEN_BIT   = 4;
    localparam int MODE_PEVEN_BIT = 5;
    localparam int MODE_STOP_LSB  = 6;

    // Command register bit positions
    localparam int CMD_TXEN_BIT   = 0;
    localparam int CMD_SBRK_BIT   = 3;

    // Framing captured when a character is moved into the shifter
    typedef struct packed {
        logic [1:0] chlen;
        logic       pen;
        logic       stop2;
    } tx_ctx_t;

    // XOR of the low (chlen+5) bits of a character; upper bits are ignored
    function automatic logic data_parity(input logic [7:0] d, input logic [1:0] chlen);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < (int'(chlen) + 5)) begin
                p = p ^ d[i];
            end else begin
                p = p;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/sio_tx_8251_if.sv
// -----------------------------------------------------------------------------
// sio_tx_8251_if
// Bus between the 8251 control-register block (master) and the transmit data
// path (slave). Carries the data-port write strobe/data, the command and mode
// fields, the baud divisor, and the TXD line plus status bits coming back.
// -----------------------------------------------------------------------------
interface sio_tx_8251_if #(
    parameter int DIV_W = 16
);
    logic             I_WR_STB;
    logic [7:0]       I_DATA;
    logic             I_TXEN;
    logic             I_SBRK;
    logic [1:0]       I_CHLEN;
    logic             I_PEN;
    logic             I_PEVEN;
    logic             I_STOP2;
    logic [DIV_W-1:0] I_BAUD_DIV;
    logic             O_TXD;
    logic             O_TXRDY;
    logic             O_TXEMPTY;
    logic             O_BUSY;

    modport master (
        output I_WR_STB, I_DATA, I_TXEN, I_SBRK, I_CHLEN, I_PEN, I_PEVEN,
               I_STOP2, I_BAUD_DIV,
        input  O_TXD, O_TXRDY, O_TXEMPTY, O_BUSY
    );

    modport slave (
        input  I_WR_STB, I_DATA, I_TXEN, I_SBRK, I_CHLEN, I_PEN, I_PEVEN,
               I_STOP2, I_BAUD_DIV,
        output O_TXD, O_TXRDY, O_TXEMPTY, O_BUSY
    );
endinterface

// File: rtl/sio_baud_gen.sv
// -----------------------------------------------------------------------------
// sio_baud_gen
// Reloadable down-counter producing one tick every (div+1) clocks while run=1.
// Ports: clk, rst (sync, active-high), load (restart count at div), run
// (count enable), div (divisor), tick (counter at zero while running).
// -----------------------------------------------------------------------------
module sio_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);
    logic [DIV_W-1:0] cnt_r;

    // Tick marks the last clock of the current bit period
    assign tick = run && (cnt_r == {DIV_W{1'b0}});

    // Down-counter: load restarts a period, reaching zero auto-reloads
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {DIV_W{1'b0}};
        end else if (load) begin
            cnt_r <= div;
        end else if (run) begin
            if (cnt_r == {DIV_W{1'b0}}) begin
                cnt_r <= div;
            end else begin
                cnt_r <= cnt_r - {{(DIV_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end
endmodule

// File: rtl/sio_tx_8251.sv
// -----------------------------------------------------------------------------
// sio_tx_8251
// Transmit data path of the 8251-compatible serial I/O. A holding register
// feeds a shift register; frames are START, 5..8 data bits LSB first, optional
// parity, 1 or 2 STOP bits. All outputs are registered, so TXD trails the FSM
// state by one clock.
// Ports: I_CLK, I_RST (sync, active-high); bus (slave modport) carrying the
// write strobe/data, TXEN/SBRK, mode fields, baud divisor, TXD and status.
// -----------------------------------------------------------------------------
module sio_tx_8251
    import sio_8251_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic          I_CLK,
    input  logic          I_RST,
    sio_tx_8251_if.slave  bus
);
    logic [2:0] state_r;
    logic [2:0] state_s;
    logic       hold_full_r;
    logic       hold_full_s;
    logic [7:0] hold_data_r;
    logic [7:0] shift_r;
    logic [2:0] bit_cnt_r;
    logic       stop_second_r;
    logic       par_bit_r;
    tx_ctx_t    ctx_r;
    logic       load_s;
    logic       last_data_s;
    logic       fsm_bit_s;
    logic       tick_s;
    logic       txd_r;
    logic       txrdy_r;
    logic       txempty_r;
    logic       busy_r;

    sio_baud_gen #(.DIV_W(DIV_W)) u_baud (
        .clk  (I_CLK),
        .rst  (I_RST),
        .load (load_s),
        .run  (state_r != ST_IDLE),
        .div  (bus.I_BAUD_DIV),
        .tick (tick_s)
    );

    assign last_data_s = (bit_cnt_r == ({1'b0, ctx_r.chlen} + 3'd4));

    // Next-state logic, shifter load decision and the FSM's line level
    always_comb begin
        state_s   = state_r;
        load_s    = 1'b0;
        fsm_bit_s = 1'b1;
        case (state_r)
            ST_IDLE: begin
                fsm_bit_s = 1'b1;
                if (hold_full_r && bus.I_TXEN) begin
                    load_s  = 1'b1;
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                fsm_bit_s = 1'b0;
                if (tick_s) begin
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                fsm_bit_s = shift_r[0];
                if (tick_s && last_data_s) begin
                    state_s = ctx_r.pen ? ST_PARITY : ST_STOP;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                fsm_bit_s = par_bit_r;
                if (tick_s) begin
                    state_s = ST_STOP;
                end else begin
                    state_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                fsm_bit_s = 1'b1;
                // Chain straight into the next START when a byte is waiting
                if (tick_s && (!ctx_r.stop2 || stop_second_r)) begin
                    if (hold_full_r && bus.I_TXEN) begin
                        load_s  = 1'b1;
                        state_s = ST_START;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                fsm_bit_s = 1'b1;
                state_s   = ST_IDLE;
            end
        endcase

        // A write in the load cycle refills the holding register
        if (bus.I_WR_STB) begin
            hold_full_s = 1'b1;
        end else if (load_s) begin
            hold_full_s = 1'b0;
        end else begin
            hold_full_s = hold_full_r;
        end
    end

    // FSM, holding register, shifter context and registered outputs
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state_r       <= ST_IDLE;
            hold_full_r   <= 1'b0;
            hold_data_r   <= 8'h00;
            shift_r       <= 8'h00;
            bit_cnt_r     <= 3'd0;
            stop_second_r <= 1'b0;
            par_bit_r     <= 1'b0;
            ctx_r         <= '0;
            txd_r         <= 1'b1;
            txrdy_r       <= 1'b0;
            txempty_r     <= 1'b1;
            busy_r        <= 1'b0;
        end else begin
            state_r     <= state_s;
            hold_full_r <= hold_full_s;
            if (bus.I_WR_STB) begin
                hold_data_r <= bus.I_DATA;
            end else begin
                hold_data_r <= hold_data_r;
            end

            if (load_s) begin
                // Mode is frozen per frame; parity is precomputed here
                shift_r       <= hold_data_r;
                ctx_r.chlen   <= bus.I_CHLEN;
                ctx_r.pen     <= bus.I_PEN;
                ctx_r.stop2   <= bus.I_STOP2;
                par_bit_r     <= bus.I_PEVEN ? data_parity(hold_data_r, bus.I_CHLEN)
                                             : ~data_parity(hold_data_r, bus.I_CHLEN);
                bit_cnt_r     <= 3'd0;
                stop_second_r <= 1'b0;
            end else if (tick_s && (state_r == ST_DATA)) begin
                shift_r   <= {1'b0, shift_r[7:1]};
                bit_cnt_r <= last_data_s ? 3'd0 : (bit_cnt_r + 3'd1);
            end else if (tick_s && (state_r == ST_STOP)) begin
                stop_second_r <= 1'b1;
            end else begin
                shift_r <= shift_r;
            end

            // Break overrides the line but the FSM keeps running underneath
            txd_r     <= bus.I_SBRK ? 1'b0 : fsm_bit_s;
            txrdy_r   <= !hold_full_s && bus.I_TXEN;
            txempty_r <= (state_s == ST_IDLE) && !hold_full_s;
            busy_r    <= (state_s != ST_IDLE);
        end
    end

    assign bus.O_TXD     = txd_r;
    assign bus.O_TXRDY   = txrdy_r;
    assign bus.O_TXEMPTY = txempty_r;
    assign bus.O_BUSY    = busy_r;
endmodule
